// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end (fetch_queue_unit, fetch_btb).
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

  // Tag is sized for the smallest legal BTB; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      ctr_next = (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
    end else begin
      ctr_next = (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup, registered update.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_next,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t     btb_q [BTB_ENTRIES];
  btb_entry_t     btb_d [BTB_ENTRIES];
  btb_entry_t     lk_entry_s;
  btb_entry_t     up_entry_s;
  logic [IDX-1:0] lk_idx_s;
  logic [IDX-1:0] up_idx_s;
  logic           unused_pc_lsb;

  function automatic logic [29:0] tag_of(input logic [31:0] pc);
    tag_of = 30'(pc >> (IDX + 2));
  endfunction

  assign lk_idx_s      = lookup_pc[IDX+1:2];
  assign up_idx_s      = upd_pc[IDX+1:2];
  assign unused_pc_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    lk_entry_s = btb_q[lk_idx_s];
    if (lk_entry_s.valid && (lk_entry_s.tag == tag_of(lookup_pc))) begin
      pred_taken = lk_entry_s.ctr[1];
    end else begin
      pred_taken = 1'b0;
    end
    pred_next = pred_taken ? lk_entry_s.target : lookup_pc + 32'd4;
  end

  // Misses only allocate on a taken resolution; not-taken misses leave the entry alone.
  always_comb begin
    btb_d      = btb_q;
    up_entry_s = btb_q[up_idx_s];
    if (upd_valid && up_entry_s.valid && (up_entry_s.tag == tag_of(upd_pc))) begin
      up_entry_s.ctr    = ctr_next(up_entry_s.ctr, upd_taken);
      up_entry_s.target = upd_taken ? upd_target : up_entry_s.target;
    end else if (upd_valid && upd_taken) begin
      up_entry_s = '{valid: 1'b1, tag: tag_of(upd_pc), target: upd_target, ctr: 2'b10};
    end else begin
      up_entry_s = btb_q[up_idx_s];
    end
    btb_d[up_idx_s] = up_entry_s;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: 30'd0, target: 32'd0, ctr: 2'b01};
      end
    end else begin
      btb_q <= btb_d;
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch front end: request FSM, inline fetch FIFO with registered head, optional BTB.
// The BTB is built only when FETCH_BTB_EN is defined; otherwise fetch is purely sequential.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int          QDEPTH      = 4,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int              PW       = $clog2(QDEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   QDEPTH_C = CW'(QDEPTH);

  fetch_state_t   state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic           imem_read_q, imem_read_d;
  logic [31:0]    imem_address_q, imem_address_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           out_valid_q, out_valid_d;
  fetch_entry_t   head_q, head_d;
  fetch_entry_t   mem_q [QDEPTH];
  fetch_entry_t   mem_d [QDEPTH];

  fetch_entry_t   enq_entry_s;
  logic           enq_s, deq_s, space_s, slot_free_s;
  logic           pred_taken_s;
  logic [31:0]    pred_next_s;

`ifdef FETCH_BTB_EN
  fetch_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (fetch_pc_q),
    .pred_taken (pred_taken_s),
    .pred_next  (pred_next_s),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );
`else
  logic unused_upd;
  assign unused_upd   = ^{upd_valid, upd_pc, upd_target, upd_taken};
  assign pred_taken_s = 1'b0;
  assign pred_next_s  = fetch_pc_q + 32'd4;
`endif

  always_comb begin
    enq_s       = (state_q == REQ) && imem_resp && !redirect_valid;
    deq_s       = out_valid_q && out_ready && !redirect_valid;
    enq_entry_s = '{instr: imem_rdata, pc: fetch_pc_q, pc_plus4: fetch_pc_q + 32'd4,
                    pred_taken: pred_taken_s, pred_target: pred_next_s};

    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(enq_s) - CW'(deq_s);
      wr_ptr_d = wr_ptr_q + PW'(enq_s);
      rd_ptr_d = rd_ptr_q + PW'(deq_s);
    end
    space_s = (count_d < QDEPTH_C);

    mem_d           = mem_q;
    mem_d[wr_ptr_q] = enq_s ? enq_entry_s : mem_q[wr_ptr_q];

    // New head is the incoming entry exactly when it lands in the slot being read next.
    out_valid_d = (count_d != '0);
    if (!out_valid_d) begin
      head_d = '0;
    end else if (enq_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = enq_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    imem_read_d    = imem_read_q;
    imem_address_d = imem_address_q;
    case (state_q)
      IDLE: begin
        slot_free_s = 1'b1;
        fetch_pc_d  = redirect_valid ? redirect_pc : fetch_pc_q;
      end
      REQ: begin
        slot_free_s = imem_resp;
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (imem_resp) begin
          fetch_pc_d = pred_next_s;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        state_d = (redirect_valid && !imem_resp) ? DROP : REQ;
      end
      DROP: begin
        slot_free_s = imem_resp;
        fetch_pc_d  = redirect_valid ? redirect_pc : fetch_pc_q;
      end
      default: begin
        slot_free_s = 1'b1;
        fetch_pc_d  = fetch_pc_q;
      end
    endcase

    // Issue only when the bus is free and the queue has a slot after this edge.
    if (slot_free_s && space_s) begin
      state_d        = REQ;
      imem_read_d    = 1'b1;
      imem_address_d = fetch_pc_d;
    end else if (slot_free_s) begin
      state_d     = IDLE;
      imem_read_d = 1'b0;
    end else begin
      imem_read_d = imem_read_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      fetch_pc_q     <= RESET_PC;
      imem_read_q    <= 1'b0;
      imem_address_q <= RESET_PC;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      head_q         <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      imem_read_q    <= imem_read_d;
      imem_address_q <= imem_address_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      out_valid_q    <= out_valid_d;
      head_q         <= head_d;
      mem_q          <= mem_d;
    end
  end

  assign imem_read       = imem_read_q;
  assign imem_address    = imem_address_q;
  assign out_valid       = out_valid_q;
  assign out_instr       = head_q.instr;
  assign out_pc          = head_q.pc;
  assign out_pc_plus4    = head_q.pc_plus4;
  assign out_pred_taken  = head_q.pred_taken;
  assign out_pred_target = head_q.pred_target;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed scoreboard bench for fetch_queue_unit; adapts predictions to FETCH_BTB_EN.
module tb_fetch_queue_unit;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_read, imem_resp, out_valid, out_ready, out_pred_taken;
  logic        redirect_valid, upd_valid, upd_taken;
  logic [31:0] imem_address, imem_rdata, out_instr, out_pc, out_pc_plus4, out_pred_target;
  logic [31:0] redirect_pc, upd_pc, upd_target;

  fetch_queue_unit dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_address(imem_address),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  m_ctr[logic [31:0]];
  logic [31:0] m_tgt[logic [31:0]];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [32:0] predict(input logic [31:0] pc);
`ifdef FETCH_BTB_EN
    if (m_ctr.exists(pc) && m_ctr[pc][1]) return {1'b1, m_tgt[pc]};
`endif
    return {1'b0, pc + 32'd4};
  endfunction

  // One clock: pop and compare the head if decode takes it this cycle, then advance.
  task automatic tick();
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1 && redirect_valid === 1'b0) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_pc", out_pc, e.pc);
        chk("out_pc_plus4", out_pc_plus4, e.pc + 32'd4);
        chk("out_pred_taken", {31'd0, out_pred_taken}, {31'd0, e.taken});
        chk("out_pred_target", out_pred_target, e.tgt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_read !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("req_seen", {31'd0, imem_read}, 32'd1);
    chk("req_addr", imem_address, exp_pc);
  endtask

  task automatic fetch(input int lat);
    logic [32:0] p;
    wait_req();
    repeat (lat - 1) tick();
    imem_resp  = 1'b1;
    imem_rdata = instr_of(imem_address);
    p = predict(exp_pc);
    sb.push_back('{instr_of(exp_pc), exp_pc, p[32], p[31:0]});
    exp_pc = p[31:0];
    tick();
    imem_resp  = 1'b0;
    imem_rdata = 32'd0;
  endtask

  // Redirect while a request is outstanding: it must be held, then its data dropped.
  task automatic redirect_to(input logic [31:0] pc);
    logic [31:0] held;
    held           = exp_pc;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    sb.delete();
    exp_pc = pc;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_hold_read", {31'd0, imem_read}, 32'd1);
    chk("drop_hold_addr", imem_address, held);
    tick();
    imem_resp  = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_resp  = 1'b0;
    chk("drop_discard", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic btb_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    tick();
    upd_valid = 1'b0;
`ifdef FETCH_BTB_EN
    if (m_ctr.exists(pc)) begin
      if (tk && m_ctr[pc] != 2'b11) m_ctr[pc] = m_ctr[pc] + 2'd1;
      else if (!tk && m_ctr[pc] != 2'b00) m_ctr[pc] = m_ctr[pc] - 2'd1;
      if (tk) m_tgt[pc] = tgt;
    end else if (tk) begin
      m_ctr[pc] = 2'b10;
      m_tgt[pc] = tgt;
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; imem_resp = 1'b0; imem_rdata = 32'd0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    upd_valid = 1'b0; upd_pc = 32'd0; upd_target = 32'd0; upd_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_addr", imem_address, RST_PC);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_pred_target", out_pred_target, 32'd0);

    // Sequential fetch with 2-cycle memory latency.
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("read_after_reset", {31'd0, imem_read}, 32'd1);
    exp_pc = RST_PC;
    repeat (3) fetch(2);
    tick();

    // Decode stalled: exactly QDEPTH fetches, then no request until a slot frees.
    out_ready = 1'b0;
    repeat (4) fetch(2);
    repeat (3) begin
      chk("full_no_req", {31'd0, imem_read}, 32'd0);
      chk("head_hold", out_pc, 32'h4000_000C);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("reissue_read", {31'd0, imem_read}, 32'd1);
    chk("reissue_addr", imem_address, 32'h4000_001C);

    // Redirect with a request outstanding.
    tick();
    redirect_to(32'h4000_0100);
    out_ready = 1'b1;
    fetch(1);

    // Taken BTB update, then the branch is fetched again.
    btb_update(32'h4000_0010, 1'b1, 32'h4000_0080);
    redirect_to(32'h4000_0010);
    fetch(2);
    fetch(2);

    // Two not-taken updates weaken the counter below the taken threshold.
    btb_update(32'h4000_0010, 1'b0, 32'd0);
    btb_update(32'h4000_0010, 1'b0, 32'd0);
    redirect_to(32'h4000_0010);
    fetch(2);
    fetch(2);

    // Redirect coinciding with a response: no drop phase, new PC requested next cycle.
    imem_resp      = 1'b1;
    imem_rdata     = instr_of(imem_address);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000_0200;
    tick();
    imem_resp      = 1'b0;
    redirect_valid = 1'b0;
    sb.delete();
    exp_pc = 32'h4000_0200;
    chk("resp_redir_valid", {31'd0, out_valid}, 32'd0);
    chk("no_drop_read", {31'd0, imem_read}, 32'd1);
    fetch(1);

    // Redirect coinciding with a dequeue: the head is flushed, not consumed.
    chk("deq_redir_pre", {31'd0, out_valid}, 32'd1);
    redirect_to(32'h4000_0300);
    fetch(1);
    tick();

    // Reset with a request outstanding; a stale response afterwards is ignored.
    rst = 1'b0;
    tick();
    tick();
    chk("mid_rst_read", {31'd0, imem_read}, 32'd0);
    chk("mid_rst_addr", imem_address, RST_PC);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_taken", {31'd0, out_pred_taken}, 32'd0);
    sb.delete();
    m_ctr.delete();
    m_tgt.delete();
    rst        = 1'b1;
    imem_resp  = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    imem_resp = 1'b0;
    chk("stale_resp_valid", {31'd0, out_valid}, 32'd0);
    exp_pc = RST_PC;
    fetch(2);
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
